// File: rtl/mem_arbiter.sv
// Shares one memory port among fetch (0), load/store (1) and DMA/debug (2), with hung-access timeout.
// Fixed priority 1 > 0 > 2 by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [2:0]            we,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            ack,
  output logic [2:0]            wait_o,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_owner, w_gnt;
  logic [ADDR_W-1:0] r_addr, w_sel_addr;
  logic [DATA_W-1:0] r_wdata, w_sel_wdata, r_rdata;
  logic              r_we, r_err, r_mem_req;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_to_hit;

  // Counter is one short of TIMEOUT on the last waiting cycle, so the bus is held exactly TIMEOUT cycles.
  assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

`ifdef MEM_ARB_RR_EN
  logic [1:0] r_rr, w_c0, w_c1;

  assign w_c0 = (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
  assign w_c1 = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;

  always_comb begin
    w_gnt = r_rr;
    if (req[w_c1]) w_gnt = w_c1;
    if (req[w_c0]) w_gnt = w_c0;
  end

  always_ff @(posedge clk) begin
    if (rst)                           r_rr <= 2'd0;
    else if (r_state == IDLE && |req)  r_rr <= w_gnt;
  end
`else
  always_comb begin
    if (req[1])      w_gnt = 2'd1;
    else if (req[0]) w_gnt = 2'd0;
    else             w_gnt = 2'd2;
  end
`endif

  always_comb begin
    case (w_gnt)
      2'd1: begin
        w_sel_addr  = addr[ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        w_sel_addr  = addr[2*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        w_sel_addr  = addr[0 +: ADDR_W];
        w_sel_wdata = wdata[0 +: DATA_W];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ack    = 3'b000;
    case (r_state)
      IDLE: if (|req) w_next = BUSY;
      BUSY: if (mem_ready || w_to_hit) w_next = DONE;
      DONE: begin
        w_next       = IDLE;
        ack[r_owner] = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= 2'd0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_mem_req <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_owner   <= w_gnt;
          r_addr    <= w_sel_addr;
          r_we      <= we[w_gnt];
          r_wdata   <= w_sel_wdata;
          r_mem_req <= 1'b1;
          r_cnt     <= '0;
        end
        BUSY: begin
          if (mem_ready) begin
            r_rdata   <= mem_rdata;
            r_mem_req <= 1'b0;
          end else begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (w_to_hit) begin
              r_rdata   <= '1;
              r_err     <= 1'b1;
              r_mem_req <= 1'b0;
            end
          end
        end
        DONE: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wait_o    = req & ~ack;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_addr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit memory port among three requesters: instruction fetch (0), data load/store (1) and external DMA/debug (2).
- The control FSM's fetch and mem states drive requesters 0 and 1 and stall on the returned wait; the external master uses the same handshake.
- Arbitrates, latches the winning transaction, holds it on the memory bus until the memory completes it, and times out hung accesses.

Parameters:
- ADDR_W, 16, address width per requester.
- DATA_W, 16, data width.
- TIMEOUT, 255, max cycles in BUSY waiting for mem_ready before forced completion; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req  input  3  per-requester request level; bit i = requester i
- addr  input  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- we  input  3  per-requester write enable
- wdata  input  3*DATA_W  packed write data
- ack  output  3  one-cycle completion pulse per requester
- wait_o  output  3  combinational: req[i] & ~ack[i]; feeds the control mem_wait
- rdata  output  DATA_W  read data, valid in the cycle ack is high
- err  output  1  high with ack when the access timed out
- mem_req  output  1  memory request
- mem_addr  output  ADDR_W  latched address
- mem_we  output  1  latched write enable
- mem_wdata  output  DATA_W  latched write data
- mem_rdata  input  DATA_W  memory read data
- mem_ready  input  1  memory completes the access this cycle

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, timeout counter=0, owner=0, rr pointer=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE with any req bit set: pick a winner; latch owner, addr, we, wdata; set mem_req=1; go to BUSY. mem_req is registered, so it rises 1 cycle after req is sampled.
- Fixed priority: 1 > 0 > 2.
- BUSY: mem_req, mem_addr, mem_we and mem_wdata held stable.
  - On mem_ready=1: latch mem_rdata into rdata, drop mem_req, go to DONE.
  - On no mem_ready: the counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: drop mem_req, rdata=16'hFFFF, err=1, go to DONE.
- DONE: ack[owner]=1 for exactly one cycle; rdata and err are valid; then go to IDLE and clear the counter and err. rdata holds until the next completion.
- Minimum latency: req sampled in IDLE (cycle 0), mem_req=1 at cycle 1, mem_ready at cycle 1, ack at cycle 2.
- Throughput: at most one access per 3 cycles.
- Requesters hold req, addr, we and wdata stable until ack. A requester must drop req the cycle after ack or it is re-arbitrated as a new access.
- Dropping req mid-access does not abort it; the access completes and ack still pulses.
- Changing addr or wdata while BUSY has no effect (already latched).
- mem_ready outside BUSY is ignored.
- Reset in any state: immediate return to IDLE, mem_req=0, no ack, in-flight access discarded.
- Counter width is clog2(TIMEOUT+1); it saturates and does not wrap.
- At most one ack bit is ever high. ack never pulses for a requester whose req was 0 when the access was granted.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. The rr pointer holds the last granted index. The search starts at (last+1) mod 3, wrapping 2 to 0. The pointer updates only on grant.
- Undefined: fixed priority 1 > 0 > 2; no rr pointer logic synthesised.
- All other behaviour is identical in both builds.

Test Plan:
- Single read: req=3'b001, addr0=16'h0100, mem_ready high on the first BUSY cycle with mem_rdata=16'hBEEF -> mem_addr=16'h0100, mem_we=0, ack=3'b001 at cycle 2, rdata=16'hBEEF, err=0.
- Simultaneous req=3'b111 held, fixed priority -> grant order 1, 1, 1 while req1 stays high. After req1 drops, grants go 0 then 2. With MEM_ARB_RR_EN: order 1, 2, 0, 1.
- Write with wait states: req=3'b010, we1=1, wdata1=16'h1234, mem_ready after 4 cycles -> mem_req high for 4 cycles with mem_wdata=16'h1234 stable, ack=3'b010 once, wait_o[1]=1 until ack.
- Timeout: TIMEOUT=8, mem_ready never asserted -> mem_req drops after 8 BUSY cycles, ack pulse with err=1 and rdata=16'hFFFF. With TIMEOUT=0 the bus holds indefinitely.
- Reset mid-access: rst=1 in cycle 3 of BUSY -> next cycle mem_req=0, ack=0, FSM IDLE. A pending req is re-granted 2 cycles after rst falls.
- Late/stray mem_ready: mem_ready=1 while IDLE and in DONE -> no ack and no state change; only one ack per grant.
